// File: rtl/core_pkg.sv
// Shared types and encodings for the core control path.
package core_pkg;

  localparam int BYTE_NUM_DEFAULT = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_FETCH_WAIT,
    S_DECODE,
    S_EXECUTE,
    S_MEM_WAIT,
    S_HALT
  } state_t;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;

  typedef enum logic [1:0] {
    WRS_ALU  = 2'b00,
    WRS_LOAD = 2'b01,
    WRS_PC4  = 2'b10,
    WRS_IMM  = 2'b11
  } wr_src_t;

  // Load extension select: MSB set means sign-extend.
  localparam logic [2:0] RDS_LB  = 3'b100;
  localparam logic [2:0] RDS_LH  = 3'b101;
  localparam logic [2:0] RDS_LW  = 3'b110;
  localparam logic [2:0] RDS_LD  = 3'b111;
  localparam logic [2:0] RDS_LBU = 3'b000;
  localparam logic [2:0] RDS_LHU = 3'b001;
  localparam logic [2:0] RDS_LWU = 3'b010;

  typedef struct packed {
    logic       alua_src;
    logic       alub_src;
    logic       aluy_src;
    logic       arithmetic;
    logic       alupc_src;
    logic       jump;
    logic       branch;
    logic       is_load;
    logic       is_store;
    logic       reg_write;
    logic [2:0] alu_src;
    logic [2:0] read_data_src;
    wr_src_t    wr_src;
    logic [2:0] funct3;
  } ctrl_t;

endpackage

// File: rtl/instruction_decoder.sv
// Combinational map from opcode/funct3/funct7 to the registered control word.
module instruction_decoder
  import core_pkg::*;
#(
  parameter int BYTE_NUM = BYTE_NUM_DEFAULT
) (
  input  logic [6:0]          i_opcode,
  input  logic [2:0]          i_funct3,
  input  logic [6:0]          i_funct7,
  output ctrl_t               o_ctrl,
  output logic [BYTE_NUM-1:0] o_byte_we,
  output logic                o_illegal
);

  logic w_unused_funct7;
  assign w_unused_funct7 = ^{i_funct7[6], i_funct7[4:0]};

  always_comb begin
    o_ctrl        = '0;
    o_byte_we     = '0;
    o_illegal     = 1'b0;
    o_ctrl.funct3 = i_funct3;
    case (i_opcode)
      OPC_OP, OPC_OP_32: begin
        o_ctrl.alu_src    = i_funct3;
        o_ctrl.arithmetic = i_funct7[5];
        o_ctrl.aluy_src   = (i_opcode == OPC_OP_32);
        o_ctrl.reg_write  = 1'b1;
      end
      OPC_OP_IMM, OPC_OP_IMM_32: begin
        o_ctrl.alub_src   = 1'b1;
        o_ctrl.alu_src    = i_funct3;
        // only SLLI/SRLI/SRAI carry funct7; other immediates reuse those bits
        o_ctrl.arithmetic = (i_funct3[1:0] == 2'b01) & i_funct7[5];
        o_ctrl.aluy_src   = (i_opcode == OPC_OP_IMM_32);
        o_ctrl.reg_write  = 1'b1;
      end
      OPC_LUI: begin
        o_ctrl.wr_src    = WRS_IMM;
        o_ctrl.reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        o_ctrl.alua_src  = 1'b1;
        o_ctrl.alub_src  = 1'b1;
        o_ctrl.reg_write = 1'b1;
      end
      OPC_JAL: begin
        o_ctrl.alua_src  = 1'b1;
        o_ctrl.alub_src  = 1'b1;
        o_ctrl.jump      = 1'b1;
        o_ctrl.wr_src    = WRS_PC4;
        o_ctrl.reg_write = 1'b1;
      end
      OPC_JALR: begin
        o_ctrl.alub_src  = 1'b1;
        o_ctrl.alupc_src = 1'b1;
        o_ctrl.jump      = 1'b1;
        o_ctrl.wr_src    = WRS_PC4;
        o_ctrl.reg_write = 1'b1;
      end
      OPC_BRANCH: begin
        o_ctrl.branch     = 1'b1;
        o_ctrl.arithmetic = 1'b1;
        o_illegal         = (i_funct3[2:1] == 2'b01);
      end
      OPC_LOAD: begin
        o_ctrl.alub_src      = 1'b1;
        o_ctrl.is_load       = 1'b1;
        o_ctrl.reg_write     = 1'b1;
        o_ctrl.wr_src        = WRS_LOAD;
        o_ctrl.read_data_src = {~i_funct3[2], i_funct3[1:0]};
        o_illegal            = (i_funct3 == 3'b111);
      end
      OPC_STORE: begin
        o_ctrl.alub_src = 1'b1;
        o_ctrl.is_store = 1'b1;
        for (int i = 0; i < BYTE_NUM; i++) begin
          o_byte_we[i] = (i < (1 << i_funct3[1:0]));
        end
        o_illegal = i_funct3[2];
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control FSM: fetch, decode into a registered control word, execute/memory.
//   state        | meaning
//   S_IDLE       | post-reset, all outputs low
//   S_FETCH      | instruction memory strobe, one cycle
//   S_FETCH_WAIT | hold strobe until instruction memory not busy
//   S_DECODE     | latch control word, trap illegal encodings
//   S_EXECUTE    | drive control word; non-memory ops retire here
//   S_MEM_WAIT   | hold data strobe until data memory not busy, then retire
//   S_HALT       | illegal instruction seen, exit by reset only
module control_unit
  import core_pkg::*;
#(
  parameter int BYTE_NUM = BYTE_NUM_DEFAULT
) (
  input  logic                i_clock,
  input  logic                i_reset_n,
  input  logic [6:0]          i_opcode,
  input  logic [2:0]          i_funct3,
  input  logic [6:0]          i_funct7,
  input  logic                i_zero,
  input  logic                i_negative,
  input  logic                i_carry_out,
  input  logic                i_overflow,
  input  logic                i_instruction_mem_busy,
  input  logic                i_data_mem_busy,
  output logic                o_instruction_mem_enable,
  output logic                o_data_mem_enable,
  output logic [BYTE_NUM-1:0] o_data_mem_byte_write_enable,
  output logic                o_alua_src,
  output logic                o_alub_src,
  output logic                o_aluy_src,
  output logic                o_carry_in,
  output logic                o_arithmetic,
  output logic                o_alupc_src,
  output logic                o_pc_src,
  output logic                o_pc_enable,
  output logic                o_write_register_enable,
  output logic [2:0]          o_alu_src,
  output logic [2:0]          o_read_data_src,
  output logic [1:0]          o_write_register_src,
  output logic                o_halted
);

  state_t              r_state, w_next_state;
  ctrl_t               r_ctrl, w_dec_ctrl;
  logic [BYTE_NUM-1:0] r_byte_we, w_dec_byte_we;
  logic                w_dec_illegal;
  logic                w_drive;
  logic                w_cond;
  logic                w_mem;

  instruction_decoder #(.BYTE_NUM(BYTE_NUM)) u_decoder (
    .i_opcode  (i_opcode),
    .i_funct3  (i_funct3),
    .i_funct7  (i_funct7),
    .o_ctrl    (w_dec_ctrl),
    .o_byte_we (w_dec_byte_we),
    .o_illegal (w_dec_illegal)
  );

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state   <= S_IDLE;
      r_ctrl    <= '0;
      r_byte_we <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_DECODE) begin
        r_ctrl    <= w_dec_ctrl;
        r_byte_we <= w_dec_byte_we;
      end
    end
  end

  assign w_mem = r_ctrl.is_load | r_ctrl.is_store;

  // BEQ/BNE use zero, BLT/BGE signed less-than, BLTU/BGEU borrow
  always_comb begin
    case (r_ctrl.funct3[2:1])
      2'b00:   w_cond = i_zero;
      2'b10:   w_cond = i_negative ^ i_overflow;
      default: w_cond = ~i_carry_out;
    endcase
  end

  always_comb begin
    w_next_state             = r_state;
    w_drive                  = 1'b0;
    o_instruction_mem_enable = 1'b0;
    o_data_mem_enable        = 1'b0;
    o_pc_enable              = 1'b0;
    o_pc_src                 = 1'b0;
    o_write_register_enable  = 1'b0;
    o_halted                 = 1'b0;
    case (r_state)
      S_IDLE: w_next_state = S_FETCH;
      S_FETCH: begin
        o_instruction_mem_enable = 1'b1;
        w_next_state             = S_FETCH_WAIT;
      end
      S_FETCH_WAIT: begin
        o_instruction_mem_enable = 1'b1;
        if (!i_instruction_mem_busy) w_next_state = S_DECODE;
      end
      S_DECODE: w_next_state = w_dec_illegal ? S_HALT : S_EXECUTE;
      S_EXECUTE: begin
        w_drive = 1'b1;
        if (w_mem) begin
          o_data_mem_enable = 1'b1;
          w_next_state      = S_MEM_WAIT;
        end else begin
          o_pc_enable             = 1'b1;
          o_write_register_enable = r_ctrl.reg_write;
          o_pc_src                = r_ctrl.jump | (r_ctrl.branch & (w_cond ^ r_ctrl.funct3[0]));
          w_next_state            = S_FETCH;
        end
      end
      S_MEM_WAIT: begin
        w_drive           = 1'b1;
        o_data_mem_enable = 1'b1;
        if (!i_data_mem_busy) begin
          o_pc_enable             = 1'b1;
          o_write_register_enable = r_ctrl.is_load;
          w_next_state            = S_FETCH;
        end
      end
      S_HALT: o_halted = 1'b1;
      default: w_next_state = S_IDLE;
    endcase
  end

  assign o_alua_src                   = w_drive & r_ctrl.alua_src;
  assign o_alub_src                   = w_drive & r_ctrl.alub_src;
  assign o_aluy_src                   = w_drive & r_ctrl.aluy_src;
  assign o_arithmetic                 = w_drive & r_ctrl.arithmetic;
  assign o_carry_in                   = w_drive & r_ctrl.arithmetic;
  assign o_alupc_src                  = w_drive & r_ctrl.alupc_src;
  assign o_alu_src                    = w_drive ? r_ctrl.alu_src : 3'b000;
  assign o_read_data_src              = w_drive ? r_ctrl.read_data_src : 3'b000;
  assign o_write_register_src         = w_drive ? r_ctrl.wr_src : 2'b00;
  assign o_data_mem_byte_write_enable = w_drive ? r_byte_we : '0;

endmodule

// File: tb/tb_control_unit.sv
// Randomized bench for control_unit against a behavioural per-instruction model.
module tb_control_unit;
  import core_pkg::*;

  typedef struct packed {
    logic       halted, imem, dmem;
    logic [7:0] bwe;
    logic       alua, alub, aluy, cin, arith, alupc, pcsrc, pcen, wren;
    logic [2:0] alu, rds;
    logic [1:0] wrs;
  } outv_t;

  typedef enum logic [3:0] {K_ALU, K_ALUI, K_LUI, K_AUIPC, K_JAL, K_JALR, K_BR, K_LD, K_ST, K_BAD} kind_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic       zero, negative, carry_out, overflow;
  logic       ibusy, dbusy;
  logic       imem_en, dmem_en, alua, alub, aluy, cin, arith, alupc, pcsrc, pcen, wren, halted;
  logic [7:0] bwe;
  logic [2:0] alu, rds;
  logic [1:0] wrs;
  outv_t      obs;
  int         vectors = 0;
  int         miscompares = 0;
  logic [6:0] opc_tab [11] = '{7'b0000011, 7'b0010011, 7'b0010111, 7'b0011011, 7'b0100011, 7'b0110011,
                               7'b0110111, 7'b0111011, 7'b1100011, 7'b1100111, 7'b1101111};

  always #5 clk = ~clk;

  control_unit #(.BYTE_NUM(8)) dut (
    .i_clock(clk), .i_reset_n(rst_n),
    .i_opcode(opcode), .i_funct3(funct3), .i_funct7(funct7),
    .i_zero(zero), .i_negative(negative), .i_carry_out(carry_out), .i_overflow(overflow),
    .i_instruction_mem_busy(ibusy), .i_data_mem_busy(dbusy),
    .o_instruction_mem_enable(imem_en), .o_data_mem_enable(dmem_en),
    .o_data_mem_byte_write_enable(bwe),
    .o_alua_src(alua), .o_alub_src(alub), .o_aluy_src(aluy), .o_carry_in(cin),
    .o_arithmetic(arith), .o_alupc_src(alupc), .o_pc_src(pcsrc), .o_pc_enable(pcen),
    .o_write_register_enable(wren), .o_alu_src(alu), .o_read_data_src(rds),
    .o_write_register_src(wrs), .o_halted(halted)
  );

  assign obs = {halted, imem_en, dmem_en, bwe, alua, alub, aluy, cin, arith, alupc, pcsrc, pcen, wren, alu, rds, wrs};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  task automatic chk(input string tag, input outv_t got, input outv_t exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %07h expected %07h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic kind_t classify(input logic [6:0] op, input logic [2:0] f3);
    case (op)
      7'b0110011, 7'b0111011: return K_ALU;
      7'b0010011, 7'b0011011: return K_ALUI;
      7'b0110111: return K_LUI;
      7'b0010111: return K_AUIPC;
      7'b1101111: return K_JAL;
      7'b1100111: return K_JALR;
      7'b1100011: return (f3 == 3'b010 || f3 == 3'b011) ? K_BAD : K_BR;
      7'b0000011: return (f3 == 3'b111) ? K_BAD : K_LD;
      7'b0100011: return (f3 > 3'b011) ? K_BAD : K_ST;
      default:    return K_BAD;
    endcase
  endfunction

  function automatic outv_t ctrl_model(input kind_t k, input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    outv_t e = '0;
    case (k)
      K_ALU:   begin e.alu = f3; e.arith = f7[5]; e.cin = f7[5]; e.aluy = (op == 7'b0111011); end
      K_ALUI:  begin
        e.alub = 1'b1; e.alu = f3; e.aluy = (op == 7'b0011011);
        e.arith = (f3 == 3'b001 || f3 == 3'b101) && f7[5]; e.cin = e.arith;
      end
      K_LUI:   e.wrs = 2'b11;
      K_AUIPC: begin e.alua = 1'b1; e.alub = 1'b1; end
      K_JAL:   begin e.alua = 1'b1; e.alub = 1'b1; e.wrs = 2'b10; end
      K_JALR:  begin e.alub = 1'b1; e.alupc = 1'b1; e.wrs = 2'b10; end
      K_BR:    begin e.arith = 1'b1; e.cin = 1'b1; end
      K_LD: begin
        e.alub = 1'b1; e.wrs = 2'b01;
        case (f3)
          3'b000: e.rds = RDS_LB;   3'b001: e.rds = RDS_LH;
          3'b010: e.rds = RDS_LW;   3'b011: e.rds = RDS_LD;
          3'b100: e.rds = RDS_LBU;  3'b101: e.rds = RDS_LHU;
          default: e.rds = RDS_LWU;
        endcase
      end
      K_ST: begin
        e.alub = 1'b1;
        case (f3[1:0])
          2'b00: e.bwe = 8'h01;  2'b01: e.bwe = 8'h03;
          2'b10: e.bwe = 8'h0F;  default: e.bwe = 8'hFF;
        endcase
      end
      default: ;
    endcase
    return e;
  endfunction

  // ALU flags of a-b: {zero, negative, carry_out, overflow}
  function automatic logic [3:0] sub_flags(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, ~b} + 9'd1;
    return {s[7:0] == 8'd0, s[7], s[8], (a[7] != b[7]) && (s[7] != a[7])};
  endfunction

  function automatic logic br_taken(input logic [2:0] f3, input logic [7:0] a, input logic [7:0] b);
    case (f3)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) < $signed(b);
      3'b101:  return $signed(a) >= $signed(b);
      3'b110:  return a < b;
      default: return a >= b;
    endcase
  endfunction

  task automatic scramble();
    opcode = 7'($urandom); funct3 = 3'($urandom); funct7 = 7'($urandom);
    {zero, negative, carry_out, overflow} = 4'($urandom);
  endtask

  task automatic cyc(input string tag, input outv_t e);
    #1;
    chk(tag, obs, e);
    @(posedge clk);
  endtask

  // Leaves the DUT just past the first edge after release (state FETCH).
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; ibusy = 1'b1; dbusy = 1'b1;
    #1; chk("reset_assert", obs, '0);
    @(posedge clk); @(negedge clk);
    #1; chk("reset_hold", obs, '0);
    rst_n = 1'b1;
    #1; chk("idle", obs, '0);
    @(posedge clk);
  endtask

  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input int ib, input int db, input logic [7:0] a, input logic [7:0] b,
                           input bit rst_mw);
    kind_t k;
    outv_t e, cw;
    k  = classify(op, f3);
    cw = ctrl_model(k, op, f3, f7);
    @(negedge clk);
    opcode = op; funct3 = f3; funct7 = f7; ibusy = 1'($urandom); dbusy = 1'($urandom);
    {zero, negative, carry_out, overflow} = 4'($urandom);
    e = '0; e.imem = 1'b1;
    cyc("fetch", e);
    for (int i = 0; i < ib; i++) begin
      @(negedge clk); ibusy = 1'b1; cyc("fetch_wait", e);
    end
    @(negedge clk); ibusy = 1'b0; cyc("fetch_wait_exit", e);
    @(negedge clk); ibusy = 1'($urandom); e = '0; cyc("decode", e);
    if (k == K_BAD) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clk); scramble(); ibusy = 1'($urandom); dbusy = 1'($urandom);
        e = '0; e.halted = 1'b1; cyc("halt", e);
      end
      do_reset();
      return;
    end
    @(negedge clk); scramble(); dbusy = 1'($urandom);
    if (k == K_BR) {zero, negative, carry_out, overflow} = sub_flags(a, b);
    e = cw;
    if (k == K_LD || k == K_ST) begin
      e.dmem = 1'b1;
      cyc("execute_mem", e);
      for (int i = 0; i < db; i++) begin
        @(negedge clk); dbusy = 1'b1; {zero, negative, carry_out, overflow} = 4'($urandom);
        if (rst_mw && i == 1) begin
          #2; rst_n = 1'b0;
          #1; chk("reset_in_mem_wait", obs, '0);
          do_reset();
          return;
        end
        cyc("mem_wait", e);
      end
      @(negedge clk); dbusy = 1'b0;
      e.pcen = 1'b1; e.wren = (k == K_LD);
      cyc("mem_wait_exit", e);
    end else begin
      e.pcen  = 1'b1;
      e.wren  = (k != K_BR);
      e.pcsrc = (k == K_JAL || k == K_JALR) || (k == K_BR && br_taken(f3, a, b));
      cyc("execute", e);
    end
  endtask

  initial begin
    logic [6:0] op;
    logic [7:0] a, b;
    opcode = '0; funct3 = '0; funct7 = '0; ibusy = 1'b0; dbusy = 1'b0;
    {zero, negative, carry_out, overflow} = 4'b0000;
    do_reset();
    run_instr(7'b0110011, 3'b000, 7'b0000000, 2, 0, 8'd0, 8'd0, 1'b0);  // ADD
    run_instr(7'b0100011, 3'b001, 7'b1010101, 0, 3, 8'd0, 8'd0, 1'b0);  // SH
    run_instr(7'b1100011, 3'b110, 7'b0000000, 1, 0, 8'd5, 8'd3, 1'b0);  // BLTU, no borrow
    run_instr(7'b1100011, 3'b110, 7'b0000000, 0, 0, 8'd3, 8'd5, 1'b0);  // BLTU, borrow
    run_instr(7'b1100011, 3'b001, 7'b0000000, 0, 0, 8'd7, 8'd9, 1'b0);  // BNE
    run_instr(7'b0000011, 3'b100, 7'b0000000, 1, 2, 8'd0, 8'd0, 1'b0);  // LBU
    run_instr(7'b0000000, 3'b000, 7'b0000000, 0, 0, 8'd0, 8'd0, 1'b0);  // illegal
    run_instr(7'b0000011, 3'b010, 7'b0000000, 0, 4, 8'd0, 8'd0, 1'b1);  // LW, reset mid MEM_WAIT
    run_instr(7'b0100011, 3'b011, 7'b0000000, 0, 0, 8'd0, 8'd0, 1'b0);  // SD
    run_instr(7'b0010011, 3'b101, 7'b0100000, 0, 0, 8'd0, 8'd0, 1'b0);  // SRAI
    for (int n = 0; n < 160; n++) begin
      op = ($urandom_range(9, 0) == 0) ? 7'($urandom) : opc_tab[$urandom_range(10, 0)];
      a  = 8'($urandom);
      b  = ($urandom_range(3, 0) == 0) ? a : 8'($urandom);
      run_instr(op, 3'($urandom), 7'($urandom), $urandom_range(3, 0), $urandom_range(3, 0), a, b, 1'b0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
